// File: rtl/interrogate_sequencer.sv
// rtl/interrogate_sequencer.sv - ISS interrogate scheduler sharing one resolver-to-digital converter across CDU channels
module interrogate_sequencer #(
    parameter int NCH       = 5,
    parameter int SELW      = 3,
    parameter int DELAY_CYC = 16,
    parameter int PULSE_CYC = 1,
    parameter int SLOT_TMO  = 8
) (
    input  logic            CLOCKH,
    input  logic            rst_n,
    input  logic            UREF1H,
    input  logic [NCH-1:0]  CHEN,
    input  logic            CONV_ACK,
    output logic            ISSIHI,
    output logic            CONV_REQ,
    output logic [SELW-1:0] CONV_SEL,
    output logic [NCH-1:0]  CHDONE,
    output logic            TIMEOUT,
    output logic            OVERRUN,
    output logic            BUSY
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DELAY = 3'd1;
    localparam logic [2:0] S_PULSE = 3'd2;
    localparam logic [2:0] S_SCAN  = 3'd3;
    localparam logic [2:0] S_REQ   = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    localparam logic [7:0]     DLY_LOAD = 8'(DELAY_CYC);
    localparam logic [3:0]     PUL_LOAD = 4'(PULSE_CYC);
    localparam logic [7:0]     TMO_LAST = 8'(SLOT_TMO - 1);
    localparam logic [NCH-1:0] CH_ONE   = NCH'(1);
    localparam logic [SELW:0]  PTR_ONE  = (SELW+1)'(1);

    logic            r_sync1, r_sync2, r_dly;
    logic [2:0]      r_vld;
    logic [2:0]      r_state;
    logic [7:0]      r_dcnt;
    logic [3:0]      r_pcnt;
    logic [7:0]      r_tcnt;
    logic [NCH-1:0]  r_mask;
    logic [SELW:0]   r_ptr;
    logic            r_issihi, r_req, r_timeout, r_overrun, r_busy;
    logic [SELW-1:0] r_sel;
    logic [NCH-1:0]  r_chdone;

    logic            w_edge;
    logic            w_found;
    logic [SELW-1:0] w_idx;
    logic [2:0]      w_nxt;

    // Edge detection is held off until the synchronizer pipeline holds real
    // samples, so a UREF1H level present at reset release is not taken as an edge.
    assign w_edge = r_vld[2] & (r_sync2 ^ r_dly);

    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (r_mask[i] && (i >= int'(r_ptr))) begin
                w_found = 1'b1;
                w_idx   = SELW'(i);
            end
        end
    end

    always_comb begin
        w_nxt = r_state;
        if (w_edge) begin
            w_nxt = S_DELAY;
        end else begin
            case (r_state)
                S_DELAY: if (r_dcnt == 8'd2) w_nxt = S_PULSE;
                S_PULSE: if (r_pcnt == 4'd1) w_nxt = S_SCAN;
                S_SCAN:  w_nxt = w_found ? S_REQ : S_IDLE;
                S_REQ:   if (CONV_ACK || (r_tcnt == TMO_LAST)) w_nxt = S_GAP;
                S_GAP:   w_nxt = S_SCAN;
                default: w_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCKH or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_dly     <= 1'b0;
            r_vld     <= '0;
            r_state   <= S_IDLE;
            r_dcnt    <= '0;
            r_pcnt    <= '0;
            r_tcnt    <= '0;
            r_mask    <= '0;
            r_ptr     <= '0;
            r_issihi  <= 1'b0;
            r_req     <= 1'b0;
            r_sel     <= '0;
            r_chdone  <= '0;
            r_timeout <= 1'b0;
            r_overrun <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_sync1   <= UREF1H;
            r_sync2   <= r_sync1;
            r_dly     <= r_sync2;
            r_vld     <= {r_vld[1:0], 1'b1};
            r_state   <= w_nxt;
            r_issihi  <= (w_nxt == S_PULSE);
            r_req     <= (w_nxt == S_REQ);
            r_busy    <= (w_nxt != S_IDLE) || (r_state != S_IDLE);
            r_chdone  <= '0;
            r_timeout <= 1'b0;
            r_overrun <= w_edge && (r_state != S_IDLE);
            if (w_edge) begin
                r_dcnt <= DLY_LOAD;
            end else begin
                case (r_state)
                    S_DELAY: begin
                        r_dcnt <= r_dcnt - 8'd1;
                        r_pcnt <= PUL_LOAD;
                    end
                    S_PULSE: begin
                        r_pcnt <= r_pcnt - 4'd1;
                        if (r_pcnt == 4'd1) begin
                            r_mask <= CHEN;
                            r_ptr  <= '0;
                        end
                    end
                    S_SCAN: begin
                        if (w_found) begin
                            r_sel  <= w_idx;
                            r_mask <= r_mask & ~(CH_ONE << w_idx);
                            r_ptr  <= {1'b0, w_idx} + PTR_ONE;
                            r_tcnt <= '0;
                        end
                    end
                    S_REQ: begin
                        if (CONV_ACK)
                            r_chdone <= CH_ONE << r_sel;
                        else if (r_tcnt == TMO_LAST)
                            r_timeout <= 1'b1;
                        else
                            r_tcnt <= r_tcnt + 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ISSIHI   = r_issihi;
    assign CONV_REQ = r_req;
    assign CONV_SEL = r_sel;
    assign CHDONE   = r_chdone;
    assign TIMEOUT  = r_timeout;
    assign OVERRUN  = r_overrun;
    assign BUSY     = r_busy;

endmodule

// File: tb/tb_interrogate_sequencer.sv
// tb/tb_interrogate_sequencer.sv - scoreboard bench for interrogate_sequencer
module tb_interrogate_sequencer;

    localparam int NCH  = 5;
    localparam int SELW = 3;

    logic            CLOCKH = 1'b0;
    logic            rst_n = 1'b0;
    logic            UREF1H = 1'b0;
    logic [NCH-1:0]  CHEN = '0;
    logic            CONV_ACK = 1'b0;
    logic            ISSIHI, CONV_REQ, TIMEOUT, OVERRUN, BUSY;
    logic [SELW-1:0] CONV_SEL;
    logic [NCH-1:0]  CHDONE;

    interrogate_sequencer #(
        .NCH(5), .SELW(3), .DELAY_CYC(16), .PULSE_CYC(1), .SLOT_TMO(8)
    ) dut (
        .CLOCKH(CLOCKH), .rst_n(rst_n), .UREF1H(UREF1H), .CHEN(CHEN),
        .CONV_ACK(CONV_ACK), .ISSIHI(ISSIHI), .CONV_REQ(CONV_REQ),
        .CONV_SEL(CONV_SEL), .CHDONE(CHDONE), .TIMEOUT(TIMEOUT),
        .OVERRUN(OVERRUN), .BUSY(BUSY)
    );

    always #5 CLOCKH = ~CLOCKH;

    int cyc = 0;
    always @(posedge CLOCKH) cyc <= cyc + 1;

    int n_run = 0;
    int n_fail = 0;

    logic [SELW-1:0] exp_sel[$];
    logic [NCH-1:0]  exp_done[$];
    logic [SELW-1:0] exp_tmo[$];
    logic [SELW-1:0] mon_sel;
    logic [NCH-1:0]  mon_done;
    bit              sb_en = 1'b0;
    logic            mon_prev_req = 1'b0;

    int   ack_mode = 0;
    int   t_rise = 0;
    logic t_prev_req = 1'b0;
    int   e_cyc = 0;

    always @(negedge CLOCKH) begin
        if (sb_en) begin
            if (CONV_REQ && !mon_prev_req) begin
                n_run++;
                if (exp_sel.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_req_sel: unexpected REQ got sel %0d expected none", CONV_SEL);
                end else begin
                    mon_sel = exp_sel.pop_front();
                    if (CONV_SEL !== mon_sel) begin
                        n_fail++;
                        $display("FAIL sb_req_sel: got %0d expected %0d at cycle %0d", CONV_SEL, mon_sel, cyc);
                    end
                end
            end
            if (CHDONE !== '0) begin
                n_run++;
                if (exp_done.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_chdone: unexpected CHDONE got %b expected none", CHDONE);
                end else begin
                    mon_done = exp_done.pop_front();
                    if (CHDONE !== mon_done) begin
                        n_fail++;
                        $display("FAIL sb_chdone: got %b expected %b at cycle %0d", CHDONE, mon_done, cyc);
                    end
                end
            end
            if (TIMEOUT) begin
                n_run++;
                if (exp_tmo.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_timeout: unexpected TIMEOUT got sel %0d expected none", CONV_SEL);
                end else begin
                    mon_sel = exp_tmo.pop_front();
                    if (CONV_SEL !== mon_sel) begin
                        n_fail++;
                        $display("FAIL sb_timeout_sel: got %0d expected %0d", CONV_SEL, mon_sel);
                    end
                end
            end
        end
        mon_prev_req = CONV_REQ;
    end

    task automatic tick();
        @(negedge CLOCKH);
        if (CONV_REQ && !t_prev_req) t_rise = cyc;
        t_prev_req = CONV_REQ;
        if (ack_mode == 1)
            CONV_ACK = CONV_REQ && (cyc == t_rise + 2);
        else if (ack_mode == 0)
            CONV_ACK = 1'b0;
    endtask

    task automatic toggle_ref();
        UREF1H = ~UREF1H;
        e_cyc = cyc + 2;
    endtask

    task automatic test_reset();
        bit seen;
        rst_n = 1'b0;
        sb_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i < 5) UREF1H = ~UREF1H;
            n_run++;
            if ({ISSIHI, CONV_REQ, CONV_SEL, CHDONE, TIMEOUT, OVERRUN, BUSY} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %b expected all zero",
                         {ISSIHI, CONV_REQ, CONV_SEL, CHDONE, TIMEOUT, OVERRUN, BUSY});
            end
        end
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (BUSY || ISSIHI) seen = 1'b1;
        end
        n_run++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_spurious_edge: got busy %0d expected 0", seen);
        end
    endtask

    task automatic test_basic();
        int first_iss, iss_cnt, first_req, fall;
        bit seen_busy;
        first_iss = -1; iss_cnt = 0; first_req = -1; fall = -1; seen_busy = 1'b0;
        CHEN = 5'b10101;
        ack_mode = 1;
        sb_en = 1'b1;
        exp_sel.push_back(3'd0); exp_sel.push_back(3'd2); exp_sel.push_back(3'd4);
        exp_done.push_back(5'b00001); exp_done.push_back(5'b00100); exp_done.push_back(5'b10000);
        tick();
        toggle_ref();
        for (int k = 0; k < 200 && fall < 0; k++) begin
            tick();
            if (ISSIHI) begin
                if (first_iss < 0) first_iss = cyc;
                iss_cnt++;
            end
            if (CONV_REQ && first_req < 0) first_req = cyc;
            if (BUSY) seen_busy = 1'b1;
            else if (seen_busy) fall = cyc;
        end
        n_run++;
        if (first_iss != e_cyc + 16) begin
            n_fail++;
            $display("FAIL basic_issihi_time: got %0d expected %0d", first_iss, e_cyc + 16);
        end
        n_run++;
        if (iss_cnt != 1) begin
            n_fail++;
            $display("FAIL basic_issihi_width: got %0d expected 1", iss_cnt);
        end
        n_run++;
        if (first_req != e_cyc + 18) begin
            n_fail++;
            $display("FAIL basic_first_req: got %0d expected %0d", first_req, e_cyc + 18);
        end
        // three channels at 5 cycles each, then SCAN and one trailing IDLE cycle
        n_run++;
        if (fall != e_cyc + 34) begin
            n_fail++;
            $display("FAIL basic_busy_fall: got %0d expected %0d", fall, e_cyc + 34);
        end
        n_run++;
        if (exp_sel.size() + exp_done.size() != 0) begin
            n_fail++;
            $display("FAIL basic_queue_drain: got %0d left expected 0", exp_sel.size() + exp_done.size());
        end
    endtask

    task automatic test_timeout();
        int req_cnt, first_req, tmo_cyc, fall;
        bit done_seen, seen_busy;
        req_cnt = 0; first_req = -1; tmo_cyc = -1; fall = -1;
        done_seen = 1'b0; seen_busy = 1'b0;
        CHEN = 5'b00010;
        ack_mode = 0;
        exp_sel.push_back(3'd1);
        exp_tmo.push_back(3'd1);
        tick();
        toggle_ref();
        for (int k = 0; k < 200 && fall < 0; k++) begin
            tick();
            if (CONV_REQ) begin
                req_cnt++;
                if (first_req < 0) first_req = cyc;
            end
            if (TIMEOUT && tmo_cyc < 0) tmo_cyc = cyc;
            if (CHDONE !== '0) done_seen = 1'b1;
            if (BUSY) seen_busy = 1'b1;
            else if (seen_busy) fall = cyc;
        end
        n_run++;
        if (req_cnt != 8) begin
            n_fail++;
            $display("FAIL timeout_req_len: got %0d expected 8", req_cnt);
        end
        n_run++;
        if (tmo_cyc != first_req + 8) begin
            n_fail++;
            $display("FAIL timeout_pulse_time: got %0d expected %0d", tmo_cyc, first_req + 8);
        end
        n_run++;
        if (done_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_no_chdone: got %0d expected 0", done_seen);
        end
        n_run++;
        if (fall != first_req + 11) begin
            n_fail++;
            $display("FAIL timeout_busy_fall: got %0d expected %0d", fall, first_req + 11);
        end
        n_run++;
        if (exp_sel.size() + exp_tmo.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_queue_drain: got %0d left expected 0", exp_sel.size() + exp_tmo.size());
        end
    endtask

    task automatic test_overrun();
        int e2, ovr_cnt, ovr_cyc, first_iss2, fall;
        bit tog2, seen_busy;
        logic req_at_ovr;
        e2 = -100; ovr_cnt = 0; ovr_cyc = -1; first_iss2 = -1; fall = -1;
        tog2 = 1'b0; seen_busy = 1'b0; req_at_ovr = 1'bx;
        CHEN = 5'b11111;
        ack_mode = 0;
        exp_sel.push_back(3'd0);
        exp_tmo.push_back(3'd0);
        exp_sel.push_back(3'd1);
        tick();
        toggle_ref();
        for (int k = 0; k < 400 && fall < 0; k++) begin
            tick();
            if (!tog2 && CONV_REQ && CONV_SEL == 3'd1 && t_rise == cyc) begin
                UREF1H = ~UREF1H;
                e2 = cyc + 2;
                tog2 = 1'b1;
                for (int c = 0; c < NCH; c++) begin
                    exp_sel.push_back(SELW'(c));
                    exp_done.push_back(NCH'(1) << c);
                end
            end
            if (OVERRUN) begin
                ovr_cnt++;
                ovr_cyc = cyc;
                req_at_ovr = CONV_REQ;
                ack_mode = 1;
            end
            if (tog2 && ISSIHI && first_iss2 < 0) first_iss2 = cyc;
            if (BUSY) seen_busy = 1'b1;
            else if (seen_busy) fall = cyc;
        end
        n_run++;
        if (ovr_cnt != 1) begin
            n_fail++;
            $display("FAIL overrun_count: got %0d expected 1", ovr_cnt);
        end
        n_run++;
        if (ovr_cyc != e2 + 1) begin
            n_fail++;
            $display("FAIL overrun_time: got %0d expected %0d", ovr_cyc, e2 + 1);
        end
        n_run++;
        if (req_at_ovr !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_req_drop: got %b expected 0", req_at_ovr);
        end
        n_run++;
        if (first_iss2 != e2 + 16) begin
            n_fail++;
            $display("FAIL overrun_issihi_again: got %0d expected %0d", first_iss2, e2 + 16);
        end
        n_run++;
        if (fall != e2 + 44) begin
            n_fail++;
            $display("FAIL overrun_busy_fall: got %0d expected %0d", fall, e2 + 44);
        end
        n_run++;
        if (exp_sel.size() + exp_done.size() + exp_tmo.size() != 0) begin
            n_fail++;
            $display("FAIL overrun_queue_drain: got %0d left expected 0",
                     exp_sel.size() + exp_done.size() + exp_tmo.size());
        end
    endtask

    task automatic test_empty();
        int busy_cnt, iss_cnt, req_cnt, fall;
        bit seen_busy;
        busy_cnt = 0; iss_cnt = 0; req_cnt = 0; fall = -1; seen_busy = 1'b0;
        CHEN = 5'b00000;
        ack_mode = 0;
        tick();
        toggle_ref();
        for (int k = 0; k < 100 && fall < 0; k++) begin
            tick();
            if (ISSIHI) iss_cnt++;
            if (CONV_REQ) req_cnt++;
            if (BUSY) begin
                busy_cnt++;
                seen_busy = 1'b1;
            end else if (seen_busy) fall = cyc;
        end
        n_run++;
        if (busy_cnt != 18) begin
            n_fail++;
            $display("FAIL empty_busy_len: got %0d expected 18", busy_cnt);
        end
        n_run++;
        if (iss_cnt != 1) begin
            n_fail++;
            $display("FAIL empty_issihi: got %0d expected 1", iss_cnt);
        end
        n_run++;
        if (req_cnt != 0) begin
            n_fail++;
            $display("FAIL empty_no_req: got %0d expected 0", req_cnt);
        end
    endtask

    task automatic test_edge_ack();
        int e2, first_iss2, fall;
        bit tog2, seen_busy;
        logic ovr_now;
        logic [NCH-1:0] chd_now;
        e2 = -100; first_iss2 = -1; fall = -1; tog2 = 1'b0; seen_busy = 1'b0;
        ovr_now = 1'bx; chd_now = 'x;
        CHEN = 5'b00011;
        ack_mode = 2;
        CONV_ACK = 1'b0;
        exp_sel.push_back(3'd0);
        tick();
        toggle_ref();
        for (int k = 0; k < 300 && fall < 0; k++) begin
            tick();
            if (!tog2 && CONV_REQ && t_rise == cyc) begin
                UREF1H = ~UREF1H;
                e2 = cyc + 2;
                tog2 = 1'b1;
                exp_sel.push_back(3'd0); exp_sel.push_back(3'd1);
                exp_done.push_back(5'b00001); exp_done.push_back(5'b00010);
            end
            if (tog2 && cyc == e2) CONV_ACK = 1'b1;
            if (tog2 && cyc == e2 + 1) begin
                CONV_ACK = 1'b0;
                ovr_now = OVERRUN;
                chd_now = CHDONE;
                ack_mode = 1;
            end
            if (tog2 && ISSIHI && first_iss2 < 0) first_iss2 = cyc;
            if (first_iss2 >= 0 && cyc == first_iss2 + 1) CHEN = 5'b11000;
            if (BUSY) seen_busy = 1'b1;
            else if (seen_busy) fall = cyc;
        end
        n_run++;
        if (ovr_now !== 1'b1) begin
            n_fail++;
            $display("FAIL edge_ack_overrun: got %b expected 1", ovr_now);
        end
        n_run++;
        if (chd_now !== 5'b00000) begin
            n_fail++;
            $display("FAIL edge_ack_chdone: got %b expected 00000", chd_now);
        end
        n_run++;
        if (fall != e2 + 29) begin
            n_fail++;
            $display("FAIL edge_ack_busy_fall: got %0d expected %0d", fall, e2 + 29);
        end
        n_run++;
        if (exp_sel.size() + exp_done.size() != 0) begin
            n_fail++;
            $display("FAIL chen_latch_queue_drain: got %0d left expected 0", exp_sel.size() + exp_done.size());
        end
    endtask

    task automatic test_reset_mid_req();
        bit got_req, seen;
        got_req = 1'b0; seen = 1'b0;
        CHEN = 5'b00001;
        ack_mode = 0;
        exp_sel.push_back(3'd0);
        tick();
        toggle_ref();
        for (int k = 0; k < 60 && !got_req; k++) begin
            tick();
            if (CONV_REQ) got_req = 1'b1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_run++;
        if (CONV_REQ !== 1'b0 || got_req !== 1'b1) begin
            n_fail++;
            $display("FAIL midreq_async_req: got req %b (reached %0d) expected 0 after reached 1", CONV_REQ, got_req);
        end
        n_run++;
        if (BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL midreq_async_busy: got %b expected 0", BUSY);
        end
        sb_en = 1'b0;
        exp_sel.delete();
        exp_tmo.delete();
        exp_done.delete();
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (BUSY || CONV_REQ || ISSIHI) seen = 1'b1;
        end
        n_run++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL midreq_idle_after_release: got %0d expected 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_overrun();
        test_empty();
        test_edge_ack();
        test_reset_mid_req();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
